factor_engine_seq: RTL and testbench
====================================

Name: factor_engine_seq

Overview:
- Parametrised sequential successor to the combinational 4x4 factorization check.
- Mode 0 (CHECK) multiplies two W-bit candidate factors with shift-add and compares the product against a 2W-bit target.
- Mode 1 (SEARCH) walks divisors upward from the smallest legal value using restoring division, and reports the first pair of factors that both fit in W bits.
- Used as the reference/oracle engine for Skolem-function benches of the factorization family.

Parameters:
- W, 4, factor width; target/product width is 2W.
- NONTRIV, 1, when 1 factors 0 and 1 are illegal (nontrivial factorization only).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0=CHECK, 1=SEARCH; captured with start.
- a  input  2W  target; captured with start.
- i1  input  W  CHECK-mode factor 1; captured with start.
- i2  input  W  CHECK-mode factor 2; captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- found  output  1  result valid/true; held until the next accepted start.
- f1  output  W  first factor of the result; held.
- f2  output  W  second factor of the result; held.

Behaviour:
- Reset (synchronous): state=IDLE. busy, done, found, f1, f2 all 0. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, MUL, DIV, EVAL.
- IDLE, start=1: capture mode/a/i1/i2, clear found/f1/f2, busy=1.
  - Next state is MUL (CHECK), or DIV with c=(NONTRIV?2:1) (SEARCH).
  - SEARCH with a==0 goes straight to EVAL and reports found=0.
- start while busy: ignored, no queuing.
- done asserts in the same cycle the FSM re-enters IDLE, so a start in the done cycle is accepted (back-to-back operation).
- MUL (CHECK mode):
  - W cycles, one partial product per cycle, i2 consumed LSB first into a 2W-bit accumulator; the result cannot overflow.
  - Then EVAL: found = (prod==a) && (!NONTRIV || (i1>1 && i2>1)); f1=i1, f2=i2.
  - done pulses W+1 clocks after the start-sampling edge.
- DIV (SEARCH mode):
  - 2W-cycle restoring division of a by c, giving a 2W-bit quotient q and a W-bit remainder r.
  - Then EVAL, 1 cycle:
    - Match = (r==0) && (q < 2^W) && (!NONTRIV || q>1).
    - On match: found=1, f1=c, f2=q, done.
    - Else if c == 2^W-1: found=0, f1=f2=0, done.
    - Else c=c+1, back to DIV.
  - Each candidate costs 2W+1 cycles; done arrives k*(2W+1) clocks after start, where k is the number of candidates evaluated.
  - Divisors are tried in increasing order, so the smallest legal f1 is returned. No f1<=f2 guarantee.
- Divisor c never reaches 0; the c counter does not wrap.
- busy deasserts in the done cycle.
- Outputs f1/f2/found are registered and stable whenever busy=0.

Test Plan:
- W=4, NONTRIV=1, CHECK, a=143, i1=11, i2=13 -> done exactly 5 clocks after start; found=1, f1=11, f2=13. Repeat with i2=12 -> found=0.
- CHECK, a=13, i1=1, i2=13 -> found=0 with NONTRIV=1; same stimulus with NONTRIV=0 -> found=1.
- SEARCH, a=143 -> candidates 2..11 (k=10); done 90 clocks after start; found=1, f1=11, f2=13.
- SEARCH, a=251 (prime) -> all 14 candidates fail; done at 126 clocks; found=0, f1=f2=0. Also SEARCH a=0 -> done 1 clock after start, found=0.
- Reset asserted for 1 cycle at clock 20 of a SEARCH -> next cycle busy=0, found/f1/f2=0; no done pulse; a fresh start is then accepted.
- start held high through an entire CHECK -> exactly one extra op accepted, and it is accepted in the done cycle. Back-to-back done pulses are 5 clocks apart; results update per op.

Source files
------------

// File: rtl/factor_engine_seq.sv
// factor_engine_seq: sequential factorization engine.
//   CHECK  (mode=0): shift-add multiply i1*i2 over W cycles, then compare with target a.
//   SEARCH (mode=1): walk divisors c upward, restoring-divide a by c over 2W cycles each,
//                    and report the first (c, a/c) pair where both factors fit in W bits.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            request pulse, accepted when idle or in the done cycle
//   mode, a, i1, i2  operation, 2W-bit target and CHECK-mode factors, captured with start
//   busy             high while an operation is in flight, low in the done cycle
//   done             one-cycle completion pulse
//   found, f1, f2    result, valid in the done cycle and held until the next accepted start
module factor_engine_seq #(
    parameter int unsigned W       = 4,
    parameter int unsigned NONTRIV = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   i1,
    input  logic [W-1:0]   i2,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [W-1:0]   f1,
    output logic [W-1:0]   f2
);

    localparam int unsigned     CW      = $clog2(2 * W);
    localparam logic [W-1:0]    CFirst  = (NONTRIV != 0) ? W'(2) : W'(1);
    localparam logic [CW-1:0]   MulLast = CW'(W - 1);
    localparam logic [CW-1:0]   DivLast = CW'(2 * W - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StEval} state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [2*W-1:0]   a_q, a_d;
    logic [W-1:0]     i1_q, i1_d, i2_q, i2_d;
    logic [2*W-1:0]   acc_q, acc_d;       // product accumulator
    logic [2*W-1:0]   mcand_q, mcand_d;   // i1 shifted left once per step
    logic [W-1:0]     mplier_q, mplier_d; // i2 shifted right once per step
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     c_q, c_d;           // current divisor candidate
    logic [W-1:0]     rem_q, rem_d;
    logic [2*W-1:0]   quo_q, quo_d;       // dividend shifts out, quotient shifts in
    logic             found_q, found_d;
    logic [W-1:0]     f1_q, f1_d, f2_q, f2_d;

    logic             chk_match, div_match, finish, accept;
    logic             res_found;
    logic [W-1:0]     res_f1, res_f2;
    logic [W:0]       rem_shift;
    logic             rem_ge;

    // Remainder never exceeds c-1, so it fits in W bits after subtraction.
    assign rem_shift = {rem_q, quo_q[2*W-1]};
    assign rem_ge    = rem_shift >= {1'b0, c_q};

    assign chk_match = (acc_q == a_q) && ((NONTRIV == 0) || ((i1_q > W'(1)) && (i2_q > W'(1))));
    assign div_match = (rem_q == '0) && (quo_q[2*W-1:W] == '0)
                       && ((NONTRIV == 0) || (quo_q > (2*W)'(1)));

    // The EVAL cycle that ends the operation is the done cycle.
    assign finish = (state_q == StEval)
                    && (!mode_q || (a_q == '0) || div_match || (c_q == '1));
    assign accept = start && ((state_q == StIdle) || finish);

    always_comb begin
        res_found = 1'b0;
        res_f1    = '0;
        res_f2    = '0;
        if (!mode_q) begin
            res_found = chk_match;
            res_f1    = i1_q;
            res_f2    = i2_q;
        end else if ((a_q != '0) && div_match) begin
            res_found = 1'b1;
            res_f1    = c_q;
            res_f2    = quo_q[W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        i1_d     = i1_q;
        i2_d     = i2_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        found_d  = found_q;
        f1_d     = f1_q;
        f2_d     = f2_q;

        unique case (state_q)
            StIdle: ;
            StMul: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == MulLast) state_d = StEval;
            end
            StDiv: begin
                rem_d = rem_ge ? (rem_shift[W-1:0] - c_q) : rem_shift[W-1:0];
                quo_d = {quo_q[2*W-2:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DivLast) state_d = StDiv == StDiv ? StEval : StEval;
            end
            StEval: begin
                if (finish) begin
                    found_d = res_found;
                    f1_d    = res_f1;
                    f2_d    = res_f2;
                    state_d = StIdle;
                end else begin
                    // Next divisor; c stops at its maximum so it never wraps.
                    c_d     = c_q + 1'b1;
                    rem_d   = '0;
                    quo_d   = a_q;
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            mode_d   = mode;
            a_d      = a;
            i1_d     = i1;
            i2_d     = i2;
            found_d  = 1'b0;
            f1_d     = '0;
            f2_d     = '0;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, i1};
            mplier_d = i2;
            cnt_d    = '0;
            c_d      = CFirst;
            rem_d    = '0;
            quo_d    = a;
            if (!mode)          state_d = StMul;
            else if (a == '0)   state_d = StEval;
            else                state_d = StDiv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mode_q   <= 1'b0;
            a_q      <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            c_q      <= CFirst;
            rem_q    <= '0;
            quo_q    <= '0;
            found_q  <= 1'b0;
            f1_q     <= '0;
            f2_q     <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            found_q  <= found_d;
            f1_q     <= f1_d;
            f2_q     <= f2_d;
        end
    end

    assign done  = finish;
    assign busy  = (state_q != StIdle) && !finish;
    // Result is presented in the done cycle and held by the registers afterwards.
    assign found = finish ? res_found : found_q;
    assign f1    = finish ? res_f1    : f1_q;
    assign f2    = finish ? res_f2    : f2_q;

endmodule

// File: tb/tb_factor_engine_seq.sv
module tb_factor_engine_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] a = '0;
    logic [3:0] i1 = '0;
    logic [3:0] i2 = '0;

    logic       busy, done, found;
    logic [3:0] f1, f2;
    logic       busy0, done0, found0;
    logic [3:0] f1_0, f2_0;

    factor_engine_seq #(.W(4), .NONTRIV(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .i1(i1), .i2(i2),
        .busy(busy), .done(done), .found(found), .f1(f1), .f2(f2)
    );

    factor_engine_seq #(.W(4), .NONTRIV(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode), .a(a), .i1(i1), .i2(i2),
        .busy(busy0), .done(done0), .found(found0), .f1(f1_0), .f2(f2_0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       found;
        logic [3:0] f1;
        logic [3:0] f2;
        int         at;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t sb0[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_found"}, int'(found), int'(e.found));
                check({e.name, "_f1"}, int'(f1), int'(e.f1));
                check({e.name, "_f2"}, int'(f2), int'(e.f2));
                check({e.name, "_cycle"}, cyc, e.at);
                check({e.name, "_busy_at_done"}, int'(busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done0) begin
            if (sb0.size() == 0) begin
                check("unexpected_done0", int'(done0), 0);
            end else begin
                e = sb0.pop_front();
                check({e.name, "_found"}, int'(found0), int'(e.found));
                check({e.name, "_f1"}, int'(f1_0), int'(e.f1));
                check({e.name, "_f2"}, int'(f2_0), int'(e.f2));
                check({e.name, "_cycle"}, cyc, e.at);
            end
        end
    end

    task automatic wait_drain(input int limit, input string name);
        int n;
        n = 0;
        while ((sb.size() + sb0.size()) != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if ((sb.size() + sb0.size()) != 0) begin
            check({name, "_timeout"}, sb.size() + sb0.size(), 0);
            sb.delete();
            sb0.delete();
        end
    endtask

    // lat: clocks from the start-sampling edge to the edge that samples done.
    task automatic op(input bit m, input logic [7:0] ta, input logic [3:0] t1,
                      input logic [3:0] t2, input bit use0, input bit ef,
                      input logic [3:0] e1, input logic [3:0] e2, input int lat,
                      input string name);
        exp_t e;
        @(negedge clk);
        mode = m; a = ta; i1 = t1; i2 = t2;
        if (use0) start0 = 1'b1; else start = 1'b1;
        e.found = ef; e.f1 = e1; e.f2 = e2; e.at = cyc + lat; e.name = name;
        if (use0) sb0.push_back(e); else sb.push_back(e);
        @(negedge clk);
        start = 1'b0; start0 = 1'b0;
        check({name, "_busy"}, int'(use0 ? busy0 : busy), int'(lat > 1));
        wait_drain(lat + 10, name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_found", int'(found), 0);
        check("rst_f1", int'(f1), 0);
        check("rst_f2", int'(f2), 0);
        check("rst_busy0", int'(busy0), 0);

        op(0, 8'd143, 4'd11, 4'd13, 0, 1, 4'd11, 4'd13, 5, "chk143");
        op(0, 8'd143, 4'd11, 4'd12, 0, 0, 4'd11, 4'd12, 5, "chk143_ne");
        op(0, 8'd13,  4'd1,  4'd13, 0, 0, 4'd1,  4'd13, 5, "chk_triv");
        op(0, 8'd13,  4'd1,  4'd13, 1, 1, 4'd1,  4'd13, 5, "chk_triv_nt0");
        op(0, 8'd225, 4'd15, 4'd15, 0, 1, 4'd15, 4'd15, 5, "chk_max");
        op(1, 8'd143, 4'd0,  4'd0,  0, 1, 4'd11, 4'd13, 90, "srch143");
        op(1, 8'd251, 4'd0,  4'd0,  0, 0, 4'd0,  4'd0, 126, "srch_prime");
        op(1, 8'd0,   4'd0,  4'd0,  0, 0, 4'd0,  4'd0,   1, "srch_zero");
        op(1, 8'd12,  4'd0,  4'd0,  0, 1, 4'd2,  4'd6,   9, "srch12");
        op(1, 8'd225, 4'd0,  4'd0,  0, 1, 4'd15, 4'd15, 126, "srch225");
        op(1, 8'd3,   4'd0,  4'd0,  0, 0, 4'd0,  4'd0, 126, "srch3");
        op(1, 8'd7,   4'd0,  4'd0,  1, 1, 4'd1,  4'd7,   9, "srch7_nt0");

        // Reset in the middle of a SEARCH: no done may follow.
        @(negedge clk);
        mode = 1'b1; a = 8'd143; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_found", int'(found), 0);
        check("abort_f1", int'(f1), 0);
        check("abort_f2", int'(f2), 0);
        repeat (100) @(negedge clk);
        op(0, 8'd143, 4'd11, 4'd13, 0, 1, 4'd11, 4'd13, 5, "post_abort");

        // start held high through a whole CHECK: one extra op, taken in the done cycle.
        @(negedge clk);
        mode = 1'b0; a = 8'd143; i1 = 4'd11; i2 = 4'd13; start = 1'b1;
        e.found = 1'b1; e.f1 = 4'd11; e.f2 = 4'd13; e.at = cyc + 5;  e.name = "held_op1";
        sb.push_back(e);
        e.found = 1'b0; e.f1 = 4'd11; e.f2 = 4'd12; e.at = cyc + 10; e.name = "held_op2";
        sb.push_back(e);
        @(negedge clk);
        i2 = 4'd12;
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_drain(30, "held");
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
